vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator; successor to the fixed-timing VGA core.
//  Timing, polarity and counter width are parameters. Adds frame-synchronous run/stop
//  control, frame/line strobes, a frame counter, and a delayed sync/DE copy that lines
//  up with a PIPE_DLY-cycle pixel pipeline (RAM read + colour path).
//  Sits between the pixel clock domain and the frame-buffer read / RGB output stage.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch (pixels)
//  H_SYNC   96   horizontal sync width (pixels)
//  H_BP     48   horizontal back porch (pixels)
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vertical sync width (lines)
//  V_BP     33   vertical back porch (lines)
//  HS_POL   0    asserted level of hs (0 = active-low)
//  VS_POL   0    asserted level of vs
//  CW       12   x/y counter width; must hold H_TOTAL-1 and V_TOTAL-1
//  PIPE_DLY 2    delay in cycles of hs_d/vs_d/de_d relative to hs/vs/de (0..15)
// PORTS
//  clk       in  1   pixel clock
//  rst_n     in  1   reset, asynchronous, active-low
//  run       in  1   level; 1 = generate frames, 0 = stop at the end of the current frame
//  hs        out 1   horizontal sync, undelayed
//  vs        out 1   vertical sync, undelayed
//  de        out 1   active-video enable (x<H_ACTIVE && y<V_ACTIVE), undelayed, combinational
//  x         out CW  horizontal counter; pixel column when de=1
//  y         out CW  vertical counter; pixel row when de=1
//  sof       out 1   1-cycle pulse at x=0,y=0 while running
//  eol       out 1   1-cycle pulse at x=H_ACTIVE-1 on active lines
//  hs_d      out 1   hs delayed PIPE_DLY cycles
//  vs_d      out 1   vs delayed PIPE_DLY cycles
//  de_d      out 1   de delayed PIPE_DLY cycles
//  frame_cnt out 16  completed frames, wraps at 2^16
//  busy      out 1   1 in RUN or DRAIN state
// BEHAVIOUR
//  - H_TOTAL = sum of H_* params; V_TOTAL = sum of V_* params (localparams).
//  - Reset: h_cnt=v_cnt=0, state=IDLE, hs=~HS_POL, vs=~VS_POL, de=0, sof=eol=0,
//    delay lines filled with the inactive levels (sync ~POL, de 0), frame_cnt=0, busy=0.
//  - FSM: IDLE -> RUN when run=1 (sampled on clk). RUN -> DRAIN when run=0.
//    DRAIN -> RUN if run returns to 1 before the frame ends; DRAIN -> IDLE on the last
//    cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1). IDLE holds counters at 0, syncs
//    inactive, de=0. The first cycle after the IDLE->RUN edge has x=0,y=0, sof=1.
//  - Counters advance only in RUN/DRAIN: h wraps H_TOTAL-1 -> 0 and, on that cycle,
//    v increments, wrapping V_TOTAL-1 -> 0. frame_cnt increments on the v wrap.
//  - hs registered: asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], giving
//    exactly H_SYNC cycles. vs registered: asserted for v in [V_ACTIVE+V_FP,
//    V_ACTIVE+V_FP+V_SYNC-1]; edges aligned with the h wrap (x=0 cycle).
//  - x,y driven directly from the counters, so a read issued for (x,y) returns data
//    aligned with de_d when the read path latency is PIPE_DLY.
//  - PIPE_DLY=0: *_d outputs equal the undelayed outputs combinationally.
//  - run toggling mid-frame never truncates a frame; no partial frames appear on vs.
//  - rst_n asserted mid-frame: all outputs go to reset values at once, asynchronously.
// STRUCTURE
//  - Shared package vga_pkg: timing localparam sets (640x480@60, 800x600@60,
//    1024x768@60, 1280x720@60) as H/V tuples, FSM state encoding (IDLE/RUN/DRAIN).
//  - One sub-module: vga_sig_delay (parametrised WIDTH x DEPTH shift register with
//    async reset value), instantiated once for {hs,vs,de}.
// TESTING
//  - Reset then run=1, 640x480 defaults: hs low 96 cycles, period 800; vs low 2 lines,
//    period 525 lines; 640*480 de cycles per frame; frame_cnt=1 after 420000 cycles.
//  - sof/eol: exactly one sof per frame at x=0,y=0; 480 eol pulses per frame at x=639.
//  - run=0 at y=100: frame completes, IDLE entered at h=799,v=524; hs/vs inactive, busy=0.
//  - run pulsed 0 then 1 within one frame: no gap, frame_cnt continues, busy stays 1.
//  - PIPE_DLY=3 and PIPE_DLY=0: de_d/hs_d/vs_d equal de/hs/vs shifted 3 cycles / 0 cycles.
//  - HS_POL=1,VS_POL=1 with tiny timing (H 8/2/2/2, V 4/1/1/1): hs high 2 cycles per
//    14, vs high 1 line per 7; mid-frame rst_n drop forces all outputs to reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing sets and timing-generator FSM encoding.
//   span_t    : one axis of a timing set (active, front porch, sync, back porch)
//   state_t   : generator state (IDLE / RUN / DRAIN)
//   span_total: period of one axis in pixels or lines
package vga_pkg;
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } span_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  localparam span_t H_640X480  = '{640, 16, 96, 48};
  localparam span_t V_640X480  = '{480, 10, 2, 33};
  localparam span_t H_800X600  = '{800, 40, 128, 88};
  localparam span_t V_800X600  = '{600, 1, 4, 23};
  localparam span_t H_1024X768 = '{1024, 24, 136, 160};
  localparam span_t V_1024X768 = '{768, 3, 6, 29};
  localparam span_t H_1280X720 = '{1280, 110, 40, 220};
  localparam span_t V_1280X720 = '{720, 5, 5, 20};
  function automatic int unsigned span_total(span_t s);
    return s.active + s.fp + s.sync + s.bp;
  endfunction
endpackage

// File: rtl/vga_sig_delay.sv
// vga_sig_delay: WIDTH x DEPTH shift register with asynchronous reset value.
//   clk, rst_n : clock, async active-low reset (loads RST_VAL into every stage)
//   d_i        : input word
//   q_o        : d_i delayed DEPTH cycles (combinational pass-through when DEPTH=0)
module vga_sig_delay #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_sr
    localparam int unsigned DW = DEPTH * WIDTH;
    logic [DW-1:0] sr_q;
    // Newest word enters at the bottom; the oldest falls off the top.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= {DEPTH{RST_VAL}};
      else sr_q <= DW'({sr_q, d_i});
    assign q_o = sr_q[DW-1 -: WIDTH];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with frame-synchronous run/stop.
//   clk, rst_n   : pixel clock, async active-low reset
//   run_i        : 1 = generate frames, 0 = stop after the current frame
//   hs_o, vs_o   : registered syncs (asserted level HS_POL / VS_POL)
//   de_o         : active video, combinational from the counters
//   x_o, y_o     : raster counters
//   sof_o, eol_o : start-of-frame / end-of-active-line strobes
//   *_d_o        : hs/vs/de delayed PIPE_DLY cycles
//   frame_cnt_o  : completed frames (wraps)
//   busy_o       : generator in RUN or DRAIN
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_640X480.active,
  parameter int unsigned H_FP     = H_640X480.fp,
  parameter int unsigned H_SYNC   = H_640X480.sync,
  parameter int unsigned H_BP     = H_640X480.bp,
  parameter int unsigned V_ACTIVE = V_640X480.active,
  parameter int unsigned V_FP     = V_640X480.fp,
  parameter int unsigned V_SYNC   = V_640X480.sync,
  parameter int unsigned V_BP     = V_640X480.bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 12,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  output logic          hs_o,
  output logic          vs_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          sof_o,
  output logic          eol_o,
  output logic          hs_d_o,
  output logic          vs_d_o,
  output logic          de_d_o,
  output logic [15:0]   frame_cnt_o,
  output logic          busy_o
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [15:0]   fc_q, fc_d;
  logic          hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, eol_q, eol_d;
  logic          busy, frame_end, busy_d;
  // Strobes and syncs are registered from the next counter values so that they
  // line up with the cycle in which x_o/y_o show the matching position.
  always_comb begin
    busy      = state_q != ST_IDLE;
    frame_end = h_q == H_MAX && v_q == V_MAX;
    // Once running, run_i only decides whether the next frame starts; a frame
    // that has begun always completes.
    state_d   = !busy ? (run_i ? ST_RUN : ST_IDLE)
              : run_i ? ST_RUN : frame_end ? ST_IDLE : ST_DRAIN;
    h_d       = !busy || h_q == H_MAX ? '0 : h_q + 1'b1;
    v_d       = !busy ? '0 : h_q != H_MAX ? v_q : v_q == V_MAX ? '0 : v_q + 1'b1;
    fc_d      = busy && frame_end ? fc_q + 1'b1 : fc_q;
    busy_d    = state_d != ST_IDLE;
    hs_d      = busy_d && h_d >= HS_BEG && h_d <= HS_END ? HS_POL : ~HS_POL;
    vs_d      = busy_d && v_d >= VS_BEG && v_d <= VS_END ? VS_POL : ~VS_POL;
    sof_d     = busy_d && h_d == '0 && v_d == '0;
    eol_d     = busy_d && h_d == H_EOL && v_d < V_ACT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign de_o        = busy && h_q < H_ACT && v_q < V_ACT;
  assign x_o         = h_q;
  assign y_o         = v_q;
  assign sof_o       = sof_q;
  assign eol_o       = eol_q;
  assign frame_cnt_o = fc_q;
  assign busy_o      = busy;
  vga_sig_delay #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({hs_o, vs_o, de_o}),
    .q_o  ({hs_d_o, vs_d_o, de_d_o})
  );
endmodule
